// File: rtl/alu_seq_if.sv
// Handshake bus for alu_seq: operand/op request side and result/flag response side.
// master drives requests and consumes results; slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             zero;
    logic             ovf;
    logic             dz;

    modport master (
        output in_valid, A, B, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, zero, ovf, dz
    );

    modport slave (
        input  in_valid, A, B, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, zero, ovf, dz
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub/compare, iterative shift-add multiply
// and restoring divide, with a valid/ready handshake on both sides.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SGTU = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;      // multiplicand, shifted left each MUL step
    logic [WIDTH-1:0] b_r;      // divisor
    logic [WIDTH-1:0] q;        // MUL: multiplier (shifts right); DIV: dividend -> quotient
    logic [WIDTH-1:0] acc;      // MUL: partial product; DIV: partial remainder
    logic [WIDTH-1:0] result;
    logic             zero_r;
    logic             ovf_r;
    logic             dz_r;
    logic             out_valid_r;

    // Single-cycle datapath, evaluated on the live inputs at acceptance
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] fast_res;
    logic             fast_ovf;
    logic             fast_dz;

    always_comb begin
        sum      = bus.A + bus.B;
        dif      = bus.A - bus.B;
        fast_res = '0;
        fast_ovf = 1'b0;
        fast_dz  = 1'b0;
        case (bus.ALUControl)
            OP_AND:  fast_res = bus.A & bus.B;
            OP_OR:   fast_res = bus.A | bus.B;
            OP_ADD: begin
                fast_res = sum;
                fast_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res = dif;
                fast_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (dif[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SGTU: fast_res = {{(WIDTH-1){1'b0}}, (bus.A > bus.B)};
            // Divide ops only take this path when B is zero
            OP_DIVU: begin
                fast_res = '1;
                fast_dz  = 1'b1;
            end
            OP_REMU: begin
                fast_res = bus.A;
                fast_dz  = 1'b1;
            end
            default: fast_res = '0;
        endcase
    end

    // One iteration of each multi-cycle algorithm
    logic [WIDTH-1:0] mul_next;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_dif;
    logic [WIDTH-1:0] div_q_next;
    logic [WIDTH-1:0] div_r_next;

    always_comb begin
        mul_next = acc + (q[0] ? a_r : '0);
        rem_sh   = {acc, q[WIDTH-1]};
        rem_dif  = rem_sh - {1'b0, b_r};
        // Restoring step: keep the difference only when it did not go negative
        if (!rem_dif[WIDTH]) begin
            div_r_next = rem_dif[WIDTH-1:0];
            div_q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            div_r_next = rem_sh[WIDTH-1:0];
            div_q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

    logic take_mul;
    logic take_div;

    assign take_mul = MUL_EN && (bus.ALUControl == OP_MUL);
    assign take_div = ((bus.ALUControl == OP_DIVU) || (bus.ALUControl == OP_REMU)) && (bus.B != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            q           <= '0;
            acc         <= '0;
            result      <= '0;
            zero_r      <= 1'b1;
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_r <= bus.ALUControl;
                        a_r  <= bus.A;
                        b_r  <= bus.B;
                        acc  <= '0;
                        cnt  <= '0;
                        if (take_mul) begin
                            q     <= bus.B;
                            state <= MUL;
                        end else if (take_div) begin
                            q     <= bus.A;
                            state <= DIV;
                        end else begin
                            q           <= bus.A;
                            result      <= fast_res;
                            zero_r      <= (fast_res == '0);
                            ovf_r       <= fast_ovf;
                            dz_r        <= fast_dz;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    a_r <= a_r << 1;
                    q   <= q >> 1;
                    cnt <= cnt + 1'b1;
                    // The last step's sum is the result, so it lands in DONE directly
                    if (cnt == LAST) begin
                        result      <= mul_next;
                        zero_r      <= (mul_next == '0);
                        ovf_r       <= 1'b0;
                        dz_r        <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_r_next;
                    q   <= div_q_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result      <= (op_r == OP_DIVU) ? div_q_next : div_r_next;
                        zero_r      <= ((op_r == OP_DIVU) ? div_q_next : div_r_next) == '0;
                        ovf_r       <= 1'b0;
                        dz_r        <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.ALUResult = result;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;
    assign bus.dz        = dz_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single operations plus hand-written
// sequences for back-pressure, busy-time input changes and mid-operation reset.
module tb_alu_seq;
    localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] SUB  = 3'b100, MUL = 3'b101, SGTU = 3'b110, REMU = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        ovf;
        logic        dz;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op with out_ready=1, measure latency and check result/flags
    task automatic run_op(input vec_t v);
        int lat;
        bus.A          = v.a;
        bus.B          = v.b;
        bus.ALUControl = v.op;
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        chk({v.name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.A        = ~v.a;
        bus.B        = ~v.b;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " result"}, 64'(bus.ALUResult), 64'(v.res));
        chk({v.name, " zero"}, 64'(bus.zero), 64'(v.res == 32'd0));
        chk({v.name, " ovf"}, 64'(bus.ovf), 64'(v.ovf));
        chk({v.name, " dz"}, 64'(bus.dz), 64'(v.dz));
        tick();
        chk({v.name, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic        busy_rdy;
        logic [31:0] held;
        int          lat;

        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, ADD,  32'h80000000, 1'b1, 1'b0, 1,  "add_ovf"});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, ADD,  32'h00000000, 1'b0, 1'b0, 1,  "add_wrap"});
        vecs.push_back('{32'h00000005, 32'h00000005, SUB,  32'h00000000, 1'b0, 1'b0, 1,  "sub_zero"});
        vecs.push_back('{32'h80000000, 32'h00000001, SUB,  32'h7FFFFFFF, 1'b1, 1'b0, 1,  "sub_ovf"});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, SGTU, 32'h00000001, 1'b0, 1'b0, 1,  "sgtu_t"});
        vecs.push_back('{32'h00000001, 32'hFFFFFFFF, SGTU, 32'h00000000, 1'b0, 1'b0, 1,  "sgtu_f"});
        vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, AND_, 32'hF000F000, 1'b0, 1'b0, 1,  "and"});
        vecs.push_back('{32'hF0F0F0F0, 32'h0F0F0000, OR_,  32'hFFFFF0F0, 1'b0, 1'b0, 1,  "or"});
        vecs.push_back('{32'd100,      32'd7,        DIVU, 32'd14,       1'b0, 1'b0, 33, "divu"});
        vecs.push_back('{32'd100,      32'd7,        REMU, 32'd2,        1'b0, 1'b0, 33, "remu"});
        vecs.push_back('{32'h80000000, 32'd3,        DIVU, 32'h2AAAAAAA, 1'b0, 1'b0, 33, "divu_big"});
        vecs.push_back('{32'h80000000, 32'd3,        REMU, 32'd2,        1'b0, 1'b0, 33, "remu_big"});
        vecs.push_back('{32'd7,        32'd100,      REMU, 32'd7,        1'b0, 1'b0, 33, "remu_small"});
        vecs.push_back('{32'd9,        32'd0,        DIVU, 32'hFFFFFFFF, 1'b0, 1'b1, 1,  "divu_dz"});
        vecs.push_back('{32'd9,        32'd0,        REMU, 32'd9,        1'b0, 1'b1, 1,  "remu_dz"});
        vecs.push_back('{32'd12345,    32'd1000,     MUL,  32'h00BC5EA8, 1'b0, 1'b0, 33, "mul"});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, MUL,  32'h00000001, 1'b0, 1'b0, 33, "mul_wrap"});

        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.ALUControl = '0;

        // Reset state
        tick();
        tick();
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst result", 64'(bus.ALUResult), 64'd0);
        chk("rst zero", 64'(bus.zero), 64'd1);
        chk("rst ovf", 64'(bus.ovf), 64'd0);
        chk("rst dz", 64'(bus.dz), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        foreach (vecs[i]) run_op(vecs[i]);

        // MUL with inputs churning while busy, then back-pressure
        bus.A          = 32'h00010000;
        bus.B          = 32'h00010001;
        bus.ALUControl = MUL;
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        tick();
        busy_rdy = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            bus.A          = $urandom;
            bus.B          = $urandom;
            bus.ALUControl = 3'($urandom_range(0, 7));
            busy_rdy       = busy_rdy | bus.in_ready;
            tick();
            lat++;
        end
        chk("mul_bp latency", 64'(lat), 64'd33);
        chk("mul_bp in_ready busy", 64'(busy_rdy | bus.in_ready), 64'd0);
        chk("mul_bp result", 64'(bus.ALUResult), 64'h00010000);
        held = bus.ALUResult;
        bus.A          = 32'd2;
        bus.B          = 32'd3;
        bus.ALUControl = ADD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mul_bp hold valid", 64'(bus.out_valid), 64'd1);
            chk("mul_bp hold result", 64'(bus.ALUResult), 64'(held));
            chk("mul_bp hold zero", 64'(bus.zero), 64'd0);
        end
        // Release with in_valid still high: the handshake cycle must not accept
        bus.out_ready = 1'b1;
        tick();
        chk("done->idle out_valid", 64'(bus.out_valid), 64'd0);
        chk("done->idle in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("next add valid", 64'(bus.out_valid), 64'd1);
        chk("next add result", 64'(bus.ALUResult), 64'd5);
        tick();

        // Reset ten cycles into a DIVU
        bus.A          = 32'd100;
        bus.B          = 32'd7;
        bus.ALUControl = DIVU;
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst result", 64'(bus.ALUResult), 64'd0);
        chk("midrst zero", 64'(bus.zero), 64'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst no result", 64'(bus.out_valid), 64'd0);
        run_op('{32'd2, 32'd3, ADD, 32'd5, 1'b0, 1'b0, 1, "post_rst_add"});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
